// File: rtl/nios2_ram_arbiter_pkg.sv
// Shared types and widths for the two-master on-chip RAM arbiter.
// Widths are fixed by the 32-bit x 15-bit-address altsyncram behind it.
package nios2_ram_pkg;

  localparam int ADDR_W = 15;
  localparam int DATA_W = 32;
  localparam int BE_W   = DATA_W / 8;

  typedef logic [0:0] master_id_t;

  localparam master_id_t M0 = 1'b0;
  localparam master_id_t M1 = 1'b1;

  typedef struct packed {
    logic       valid;
    master_id_t owner;
  } rd_pipe_entry_t;

endpackage

// File: rtl/nios2_ram_arbiter_if.sv
// Avalon-MM style master bus and the RAM-side port bundle used by the arbiter.
interface nios2_avmm_if;
  import nios2_ram_pkg::*;

  logic [ADDR_W-1:0] address;
  logic [BE_W-1:0]   byteenable;
  logic              read;
  logic              write;
  logic [DATA_W-1:0] writedata;
  logic              waitrequest;
  logic [DATA_W-1:0] readdata;
  logic              readdatavalid;

  modport master (
    output address, byteenable, read, write, writedata,
    input  waitrequest, readdata, readdatavalid
  );

  modport slave (
    input  address, byteenable, read, write, writedata,
    output waitrequest, readdata, readdatavalid
  );
endinterface

interface nios2_ram_if;
  import nios2_ram_pkg::*;

  logic [ADDR_W-1:0] address;
  logic [BE_W-1:0]   byteenable;
  logic              chipselect;
  logic              write;
  logic [DATA_W-1:0] writedata;
  logic              clken;
  logic [DATA_W-1:0] readdata;

  modport master (
    output address, byteenable, chipselect, write, writedata, clken,
    input  readdata
  );

  modport slave (
    input  address, byteenable, chipselect, write, writedata, clken,
    output readdata
  );
endinterface

// File: rtl/nios2_ram_arbiter_rr_arb2.sv
// Two-way round-robin grant. On a tie the master that did not win last time wins;
// the pointer only moves on cycles where something is granted.
module nios2_rr_arb2
  import nios2_ram_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic [1:0] req,
  output logic [1:0] gnt,
  output master_id_t winner,
  output logic       any_gnt
);

  master_id_t last_gnt_reg;
  master_id_t last_gnt_next;

  always_comb begin
    winner        = M0;
    gnt           = 2'b00;
    any_gnt       = |req;
    last_gnt_next = last_gnt_reg;

    case (req)
      2'b01:   winner = M0;
      2'b10:   winner = M1;
      2'b11:   winner = ~last_gnt_reg;
      default: winner = last_gnt_reg;
    endcase

    if (any_gnt) begin
      gnt[winner]   = 1'b1;
      last_gnt_next = winner;
    end
  end

  // Reset to M1 so master 0 wins the first tie.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_gnt_reg <= M1;
    end else begin
      last_gnt_reg <= last_gnt_next;
    end
  end

endmodule

// File: rtl/nios2_ram_arbiter.sv
// Arbitrates CPU (m0) and DMA (m1) onto the single RAM port; one access per
// cycle, read data returned in accept order through an owner-tagged pipe.
module nios2_ram_arbiter
  import nios2_ram_pkg::*;
#(
  parameter int RD_LATENCY = 1
) (
  input  logic              clk,
  input  logic              reset_n,
  nios2_avmm_if.slave       m0,
  nios2_avmm_if.slave       m1,
  nios2_ram_if.master       ram
);

  logic [1:0]        req;
  logic [1:0]        gnt;
  master_id_t        winner;
  logic              any_gnt;

  logic [ADDR_W-1:0] sel_address;
  logic [BE_W-1:0]   sel_byteenable;
  logic              sel_read;
  logic              sel_write;
  logic [DATA_W-1:0] sel_writedata;
  logic              rd_accept;

  logic [ADDR_W-1:0] addr_hold_reg;
  rd_pipe_entry_t    rd_pipe_reg [RD_LATENCY];
  rd_pipe_entry_t    rd_head;

  // Requests are masked in reset so waitrequest stays high and the RAM is idle.
  assign req = {m1.read | m1.write, m0.read | m0.write} & {2{reset_n}};

  nios2_rr_arb2 u_arb (
    .clk     (clk),
    .reset_n (reset_n),
    .req     (req),
    .gnt     (gnt),
    .winner  (winner),
    .any_gnt (any_gnt)
  );

  always_comb begin
    sel_address    = m0.address;
    sel_byteenable = m0.byteenable;
    sel_read       = m0.read;
    sel_write      = m0.write;
    sel_writedata  = m0.writedata;
    if (winner == M1) begin
      sel_address    = m1.address;
      sel_byteenable = m1.byteenable;
      sel_read       = m1.read;
      sel_write      = m1.write;
      sel_writedata  = m1.writedata;
    end
  end

  // A simultaneous read+write is serviced as a write only.
  assign rd_accept = any_gnt & sel_read & ~sel_write;

  assign ram.chipselect = any_gnt;
  assign ram.write      = any_gnt & sel_write;
  assign ram.address    = any_gnt ? sel_address : addr_hold_reg;
  assign ram.byteenable = sel_byteenable;
  assign ram.writedata  = sel_writedata;
  assign ram.clken      = reset_n;

  assign m0.waitrequest = ~gnt[0];
  assign m1.waitrequest = ~gnt[1];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      addr_hold_reg <= '0;
    end else if (any_gnt) begin
      addr_hold_reg <= sel_address;
    end
  end

  generate
    for (genvar gi = 0; gi < RD_LATENCY; gi++) begin : g_rd_pipe
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          rd_pipe_reg[gi] <= '0;
        end else if (gi == 0) begin
          rd_pipe_reg[gi] <= '{valid: rd_accept, owner: winner};
        end else begin
          rd_pipe_reg[gi] <= rd_pipe_reg[(gi == 0) ? 0 : gi-1];
        end
      end
    end
  endgenerate

  assign rd_head = rd_pipe_reg[RD_LATENCY-1];

  assign m0.readdatavalid = rd_head.valid & (rd_head.owner == M0);
  assign m1.readdatavalid = rd_head.valid & (rd_head.owner == M1);
  assign m0.readdata      = ram.readdata;
  assign m1.readdata      = ram.readdata;

endmodule
